// File: rtl/pwm_gen_multi_if.sv
// Control/status bundle for pwm_gen_multi: run enable, shadow-register load port,
// and the registered gate outputs.
interface pwm_gen_multi_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             en;
    logic [CNT_W-1:0] period;
    logic             ld;
    logic [CH_W-1:0]  ld_ch;
    logic [CNT_W-1:0] ld_duty;
    logic [CNT_W-1:0] ld_phase;
    logic [DT_W-1:0]  dead_time;
    logic [N_CH-1:0]  pwm_hi;
    logic [N_CH-1:0]  pwm_lo;
    logic             cyc_start;

    modport master (
        output en, period, ld, ld_ch, ld_duty, ld_phase, dead_time,
        input  pwm_hi, pwm_lo, cyc_start
    );

    modport slave (
        input  en, period, ld, ld_ch, ld_duty, ld_phase, dead_time,
        output pwm_hi, pwm_lo, cyc_start
    );
endinterface

// File: rtl/pwm_gen_multi.sv
// N-channel PWM generator: shared period, per-channel duty/phase, double-buffered updates.
// Define PWM_DEADTIME_EN to insert per-channel dead-time between pwm_hi and pwm_lo.
module pwm_gen_multi #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_gen_multi_if.slave bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             en_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_e;
    logic [CNT_W-1:0] duty_q    [N_CH];
    logic [CNT_W-1:0] phase_q   [N_CH];
    logic [CNT_W-1:0] duty_s_q  [N_CH];
    logic [CNT_W-1:0] phase_s_q [N_CH];
    logic             rise, wrap, copy;
    logic [N_CH-1:0]  raw, hi_d, lo_d, hi_q, lo_q;
    logic             cyc_q;

    // On the enable edge the shadow set is used directly, so the first cycle is already fresh
    assign rise  = bus.en && !en_q;
    assign per_e = rise ? bus.period : per_q;
    assign wrap  = bus.en && (cnt_q == per_e);
    assign copy  = wrap || rise;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!bus.en || (cnt_q == per_e)) cnt_d = '0;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] duty_e, phase_e;
        logic [CNT_W:0]   per_x, ph, sum, loc;

        assign duty_e  = rise ? duty_s_q[i]  : duty_q[i];
        assign phase_e = rise ? phase_s_q[i] : phase_q[i];
        assign per_x   = {1'b0, per_e};
        assign ph      = (phase_e > per_e) ? '0 : {1'b0, phase_e};
        assign sum     = {1'b0, cnt_q} + ph;
        assign loc     = (sum > per_x) ? (sum - per_x - (CNT_W+1)'(1)) : sum;
        assign raw[i]  = bus.en && (loc < {1'b0, duty_e});
    end

`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0] dt_q [N_CH];
    logic [DT_W-1:0] dt_d [N_CH];
    logic [N_CH-1:0] raw_q;

    // The timer is judged on its next value so a freshly loaded edge blanks this very cycle
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dt_d[i] = dt_q[i];
            if (raw[i] != raw_q[i])  dt_d[i] = bus.dead_time;
            else if (dt_q[i] != '0)  dt_d[i] = dt_q[i] - DT_W'(1);
            hi_d[i] = raw[i] && (dt_d[i] == '0);
            lo_d[i] = bus.en && !raw[i] && (dt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
            for (int i = 0; i < N_CH; i++) dt_q[i] <= '0;
        end else begin
            raw_q <= raw;
            for (int i = 0; i < N_CH; i++) dt_q[i] <= dt_d[i];
        end
    end
`else
    assign hi_d = raw;
    assign lo_d = {N_CH{bus.en}} & ~raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            cnt_q <= '0;
            per_q <= '0;
            cyc_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i]    <= '0;
                phase_q[i]   <= '0;
                duty_s_q[i]  <= '0;
                phase_s_q[i] <= '0;
            end
        end else begin
            en_q  <= bus.en;
            cnt_q <= cnt_d;
            cyc_q <= bus.en && (cnt_q == '0);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (copy) per_q <= bus.period;
            // Copy reads the pre-write shadow; a coincident ld lands at the following wrap
            for (int i = 0; i < N_CH; i++) begin
                if (copy) begin
                    duty_q[i]  <= duty_s_q[i];
                    phase_q[i] <= phase_s_q[i];
                end
                if (bus.ld && (bus.ld_ch == CH_W'(i))) begin
                    duty_s_q[i]  <= bus.ld_duty;
                    phase_s_q[i] <= bus.ld_phase;
                end
            end
        end
    end

    assign bus.pwm_hi    = hi_q;
    assign bus.pwm_lo    = lo_q;
    assign bus.cyc_start = cyc_q;
endmodule
